// File: rtl/pattern_generator_pkg.sv
// Shared definitions for the pattern generator.
// Holds the 2-bit FSM state encoding and the default width constants
// used by pattern_generator and pattern_serializer.
package pattern_generator_pkg;

  localparam int PAT_W_DEF = 8;  // default maximum pattern length in bits
  localparam int REP_W_DEF = 8;  // default repeat-counter width

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/pattern_serializer.sv
// Bit-index datapath for the pattern generator.
// Holds the captured pattern, its length and the current bit index.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load         capture pattern/len and restart at bit index 0
//   advance      step to the next bit, wrapping to 0 after the last one
//   pattern      pattern bits (low len bits used, MSB of that field first)
//   len          pattern length in bits
//   next_bit     bit that will be current after this clock edge
//                (lets the top register data_o without a cycle of lag)
//   last         current bit index is len-1
module pattern_serializer
  import pattern_generator_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       advance,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W+1)-1:0] len,
  output logic                       next_bit,
  output logic                       last
);

  localparam int LEN_W = $clog2(PAT_W+1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] idx;
  logic [PAT_W-1:0] shifted;

  assign last = (cnt_q == len_q - LEN_W'(1));

  // NOTE: every signal written here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    cnt_d = cnt_q;
    if (load) begin
      pat_d = pattern;
      len_d = len;
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = last ? '0 : cnt_q + LEN_W'(1);
    end
    // MSB of the used field goes out first: index len-1-cnt.
    // A shift avoids an over-wide part-select index.
    idx      = len_d - LEN_W'(1) - cnt_d;
    shifted  = pat_d >> idx;
    next_bit = shifted[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_generator.sv
// Serial pattern generator: transmits the low len_i bits of pattern_i,
// MSB first, repeat_i times, then pulses done_o.
// Optional feature macro: PATTERN_GENERATOR_GAP_EN inserts one idle GAP
// cycle between consecutive repetitions.
// Ports:
//   clk_i      clock, rising edge
//   reset_i    synchronous active-low reset
//   start_i    start request, sampled only in IDLE
//   abort_i    abandon the current transmission (no done_o)
//   pattern_i  pattern bits; len_i  length; repeat_i  repetition count
//   data_o     registered serial data (0 whenever valid_o is 0)
//   valid_o    registered, data_o carries a pattern bit
//   busy_o     registered, transmission in progress (SHIFT or GAP)
//   done_o     registered one-cycle completion pulse
module pattern_generator
  import pattern_generator_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [PAT_W-1:0]           pattern_i,
  input  logic [$clog2(PAT_W+1)-1:0] len_i,
  input  logic [REP_W-1:0]           repeat_i,
  output logic                       data_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int LEN_W = $clog2(PAT_W+1);

  logic [1:0]       state, state_nxt;
  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic [REP_W-1:0] rep_tgt, rep_tgt_nxt;
  logic             load, advance;
  logic             next_bit, last;
  logic             bad_req;

  // Degenerate requests finish immediately without any valid_o cycle.
  assign bad_req = (len_i == '0) || (len_i > LEN_W'(PAT_W)) || (repeat_i == '0);

  pattern_serializer #(
    .PAT_W (PAT_W)
  ) u_serializer (
    .clk      (clk_i),
    .rst_n    (reset_i),
    .load     (load),
    .advance  (advance),
    .pattern  (pattern_i),
    .len      (len_i),
    .next_bit (next_bit),
    .last     (last)
  );

  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    rep_tgt_nxt = rep_tgt;
    load        = 1'b0;
    advance     = 1'b0;
    case (state)
      S_IDLE: begin
        // Abort outranks start when both arrive together.
        if (start_i && !abort_i) begin
          load        = 1'b1;
          rep_tgt_nxt = repeat_i;
          rep_cnt_nxt = '0;
          state_nxt   = bad_req ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          state_nxt = S_IDLE;
        end else begin
          advance = 1'b1;
          if (last) begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
            if (rep_cnt == rep_tgt - REP_W'(1)) begin
              state_nxt = S_DONE;
            end else begin
`ifdef PATTERN_GENERATOR_GAP_EN
              state_nxt = S_GAP;
`else
              state_nxt = S_SHIFT;
`endif
            end
          end
        end
      end
      S_GAP:   state_nxt = abort_i ? S_IDLE : S_SHIFT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state they describe.
  // NOTE: datapath and output registers are reset along with the FSM so
  // no stale value reaches the pins after a mid-transmission reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state   <= S_IDLE;
      rep_cnt <= '0;
      rep_tgt <= '0;
      data_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rep_cnt <= rep_cnt_nxt;
      rep_tgt <= rep_tgt_nxt;
      data_o  <= (state_nxt == S_SHIFT) && next_bit;
      valid_o <= (state_nxt == S_SHIFT);
      busy_o  <= (state_nxt == S_SHIFT) || (state_nxt == S_GAP);
      done_o  <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Directed testbench for pattern_generator with hand-computed streams.
// Expectations follow the GAP build when PATTERN_GENERATOR_GAP_EN is set.
module tb_pattern_generator;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       abort_i;
  logic [7:0] pattern_i;
  logic [3:0] len_i;
  logic [7:0] repeat_i;
  logic       data_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_pass   = 0;

  pattern_generator #(
    .PAT_W (8),
    .REP_W (8)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .pattern_i (pattern_i),
    .len_i     (len_i),
    .repeat_i  (repeat_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r);
    pattern_i = p;
    len_i     = l;
    repeat_i  = r;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, valid_o, 1'b0);
    check({tag, ".data"},  data_o,  1'b0);
    check({tag, ".busy"},  busy_o,  1'b0);
    check({tag, ".done"},  done_o,  1'b0);
  endtask

  // Checks n cycles of the stream (v/d, oldest cycle in bit n-1), then
  // the done pulse and its single-cycle width. pulse_at >= 0 injects a
  // foreign start request at that cycle, which must be ignored.
  task automatic run_stream(input string tag, input int n, input logic [15:0] v,
                            input logic [15:0] d, input int pulse_at);
    logic [15:0] sv, sd;
    for (int i = 0; i < n; i++) begin
      sv = v >> (n - 1 - i);
      sd = d >> (n - 1 - i);
      check($sformatf("%s.valid[%0d]", tag, i), valid_o, sv[0]);
      check($sformatf("%s.data[%0d]",  tag, i), data_o,  sd[0]);
      check($sformatf("%s.busy[%0d]",  tag, i), busy_o,  1'b1);
      check($sformatf("%s.done[%0d]",  tag, i), done_o,  1'b0);
      if (i == pulse_at) begin
        pattern_i = 8'hFF;
        len_i     = 4'd8;
        repeat_i  = 8'd5;
        start_i   = 1'b1;
      end
      step();
      start_i = 1'b0;
    end
    check({tag, ".done_pulse"}, done_o,  1'b1);
    check({tag, ".done_busy"},  busy_o,  1'b0);
    check({tag, ".done_valid"}, valid_o, 1'b0);
    check({tag, ".done_data"},  data_o,  1'b0);
    step();
    check_idle({tag, ".after"});
  endtask

  initial begin
    reset_i   = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    pattern_i = '0;
    len_i     = '0;
    repeat_i  = '0;
    step();
    step();
    check_idle("reset");
    reset_i = 1'b1;
    step();
    check_idle("idle");

    // 8'h05, len 3, repeat 2
    start_tx(8'h05, 4'd3, 8'd2);
`ifdef PATTERN_GENERATOR_GAP_EN
    run_stream("p05x2", 7, 16'b1110111, 16'b1010101, -1);
`else
    run_stream("p05x2", 6, 16'b111111, 16'b101101, -1);
`endif

    // Full-width pattern, MSB first
    start_tx(8'hA5, 4'd8, 8'd1);
    run_stream("pA5", 8, 16'hFF, 16'hA5, -1);

    // Upper pattern bits beyond len are ignored: low 4 bits of F6 = 0110
    start_tx(8'hF6, 4'd4, 8'd1);
    run_stream("pF6l4", 4, 16'hF, 16'h6, -1);

    // Degenerate requests: done on the cycle after start, no valid_o
    start_tx(8'hFF, 4'd0, 8'd3);
    check("len0.done", done_o, 1'b1);
    check("len0.valid", valid_o, 1'b0);
    step();
    check_idle("len0.after");
    start_tx(8'hFF, 4'd4, 8'd0);
    check("rep0.done", done_o, 1'b1);
    check("rep0.valid", valid_o, 1'b0);
    step();
    check_idle("rep0.after");
    start_tx(8'hFF, 4'd9, 8'd1);
    check("len9.done", done_o, 1'b1);
    check("len9.valid", valid_o, 1'b0);
    step();
    check_idle("len9.after");

    // Abort on the second bit of A5
    start_tx(8'hA5, 4'd8, 8'd1);
    check("abort.bit0", data_o, 1'b1);
    step();
    check("abort.bit1", data_o, 1'b0);
    check("abort.bit1_valid", valid_o, 1'b1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_idle("abort.next");
    step();
    check_idle("abort.later");
    // New start accepted afterwards
    start_tx(8'h05, 4'd3, 8'd1);
    run_stream("abort.restart", 3, 16'b111, 16'b101, -1);

    // Abort and start together in IDLE: abort wins
    abort_i   = 1'b1;
    start_tx(8'hA5, 4'd8, 8'd1);
    abort_i   = 1'b0;
    check_idle("abort_start");
    step();
    check_idle("abort_start.later");

    // Reset mid-SHIFT while data_o is 1
    start_tx(8'hA5, 4'd8, 8'd2);
    check("rst.bit0", data_o, 1'b1);
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    check_idle("rst.next");
    step();
    check_idle("rst.later");
    step();
    check_idle("rst.later2");

    // Start pulsed while busy: ignored, stream unchanged
    start_tx(8'h05, 4'd3, 8'd2);
`ifdef PATTERN_GENERATOR_GAP_EN
    run_stream("busy_start", 7, 16'b1110111, 16'b1010101, 2);
`else
    run_stream("busy_start", 6, 16'b111111, 16'b101101, 2);
`endif
    step();
    check_idle("busy_start.idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_generator.md
PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 Parameter: PAT_W, 8, maximum pattern length in bits (2..16).
REQ-002 Parameter: REP_W, 8, width of the repeat counter.
REQ-003 The block SHALL have a single clock and a reset that is synchronous and active-low.
REQ-004 Port: clk_i  input  1  clock; all logic on the rising edge.
REQ-005 Port: reset_i  input  1  synchronous active-low reset.
REQ-006 Port: start_i  input  1  request to transmit; sampled only in IDLE.
REQ-007 Port: abort_i  input  1  synchronous abort of the current transmission.
REQ-008 Port: pattern_i  input  PAT_W  pattern bits; the low len_i bits are used.
REQ-009 Port: len_i  input  $clog2(PAT_W+1)  pattern length in bits.
REQ-010 Port: repeat_i  input  REP_W  number of back-to-back pattern repetitions.
REQ-011 Port: data_o  output  1  serial data, registered.
REQ-012 Port: valid_o  output  1  data_o carries a pattern bit this cycle, registered.
REQ-013 Port: busy_o  output  1  a transmission is in progress.
REQ-014 Port: done_o  output  1  one-cycle pulse when a transmission completes.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT, GAP and DONE.
REQ-016 In IDLE with start_i=1, the block SHALL capture pattern_i, len_i and repeat_i, and SHALL present the first bit on the next cycle.
REQ-017 If len_i=0, len_i>PAT_W or repeat_i=0 at start, the block SHALL go directly to DONE, with no valid_o cycles.
REQ-018 In SHIFT: valid_o=1, busy_o=1, and data_o=pattern[len-1-bitcnt], MSB of the used field first.
REQ-019 At bitcnt=len-1, bitcnt SHALL wrap to 0, and the repeat counter SHALL increment.
REQ-020 After the last bit of the last repetition, the FSM SHALL go to DONE.
REQ-021 Otherwise, after the last bit of a repetition, the FSM SHALL stay in SHIFT, or go to GAP when the macro of REQ-032 is defined.
REQ-022 Without gaps, a transmission SHALL occupy exactly len*repeat consecutive valid_o cycles.
REQ-023 In GAP (one cycle): valid_o=0, data_o=0 and busy_o=1, then the FSM SHALL return to SHIFT.
REQ-024 In DONE (one cycle): done_o=1, busy_o=0 and valid_o=0, then the FSM SHALL go to IDLE.
REQ-025 start_i SHALL be ignored outside IDLE, and captured values SHALL NOT change mid-transmission.
REQ-026 abort_i=1 in SHIFT or GAP SHALL force IDLE on the next cycle: valid_o=0, busy_o=0 and no done_o pulse.
REQ-027 If abort_i and start_i are both 1 in IDLE, abort SHALL win and start SHALL be ignored.
REQ-028 When valid_o=0, data_o SHALL be 0.

Reset
REQ-029 With reset_i=0 at a clock edge, the state SHALL become IDLE and the counters SHALL become 0.
REQ-030 With reset_i=0 at a clock edge, data_o, valid_o, busy_o and done_o SHALL become 0.
REQ-031 Reset SHALL take priority over abort_i and start_i, including mid-transmission, and no done_o pulse SHALL follow.

Configuration
REQ-032 Macro PATTERN_GENERATOR_GAP_EN defined: one GAP cycle SHALL be inserted between consecutive repetitions.
REQ-033 With that macro defined, total transmission cycles SHALL be len*repeat + (repeat-1).
REQ-034 Macro undefined: repetitions SHALL be back-to-back, and the GAP state SHALL be unreachable.

Structure
REQ-035 Package pattern_generator_pkg SHALL hold the state encoding (2-bit: IDLE=0, SHIFT=1, GAP=2, DONE=3) and the default PAT_W/REP_W constants.
REQ-036 The shift/bit-index datapath SHALL be a sub-module, pattern_serializer (load, advance, current bit, last-bit flag); the FSM and repeat counter SHALL stay in the top.

Verification
REQ-037 Scenario: pattern_i=8'h05, len_i=3, repeat_i=2, no gap -> data_o=1,0,1,1,0,1 with valid_o high 6 cycles, then done_o high exactly once.
REQ-038 Scenario: same stimulus with PATTERN_GENERATOR_GAP_EN -> 1,0,1,(gap, valid_o=0),1,0,1, then done_o; 7 cycles busy.
REQ-039 Scenario: len_i=0 or repeat_i=0 with start_i -> no valid_o, done_o pulses on the cycle after start.
REQ-040 Scenario: abort_i asserted on the 2nd bit of pattern 8'hA5, len 8 -> valid_o=0 next cycle, no done_o, and a new start is accepted afterwards.
REQ-041 Scenario: reset_i=0 mid-SHIFT -> all outputs 0 next edge; start_i pulsed during busy_o=1 -> ignored, and the bit count is unchanged.
